// File: rtl/scara_seq_ctrl.sv
// -----------------------------------------------------------------------------
// scara_seq_ctrl
//
// Command sequencer for a SCARA arm that carries one product from conveyor 1
// (pos 0) through NUM_STATIONS process stations (pos 1..NUM_STATIONS) to
// conveyor 2 (pos NUM_STATIONS+1). Each station holds the product for a
// configurable dwell time before the arm may pick it up again.
//
// Optional feature: define SCARA_SEQ_WATCHDOG_EN to build an idle watchdog
// that halts the sequence after WD_LIMIT consecutive idle cycles in a wait
// phase. Without the macro, timeout is tied to 0 and no watchdog exists.
//
// Ports
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   cmd_valid        command offered
//   cmd[2:0]         MOVE/PICK/PLACE/HOME/STOP/RESUME (110/111 invalid)
//   cmd_ready        command taken when cmd_valid && cmd_ready at an edge
//   dwell_cfg        per-station dwell, station k at [k*DWELL_W +: DWELL_W]
//   phase[2:0]       IDLE, WAIT_PICK, WAIT_MOVE, WAIT_PLACE, DWELL, PLACED,
//                    HALTED (0..6)
//   pos[3:0]         current arm position
//   product_complete one-cycle pulse per product delivered to conveyor 2
//   error            one-cycle pulse per rejected command
//   timeout          one-cycle pulse on watchdog expiry
//   product_count    products delivered, wraps at all-ones
// -----------------------------------------------------------------------------
module scara_seq_ctrl #(
  parameter int NUM_STATIONS = 3,
  parameter int DWELL_W      = 8,
  parameter int CNT_W        = 16,
  parameter int WD_LIMIT     = 255
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            cmd_valid,
  input  logic [2:0]                      cmd,
  output logic                            cmd_ready,
  input  logic [NUM_STATIONS*DWELL_W-1:0] dwell_cfg,
  output logic [2:0]                      phase,
  output logic [3:0]                      pos,
  output logic                            product_complete,
  output logic                            error,
  output logic                            timeout,
  output logic [CNT_W-1:0]                product_count
);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_WPICK  = 3'd1;
  localparam logic [2:0] PH_WMOVE  = 3'd2;
  localparam logic [2:0] PH_WPLACE = 3'd3;
  localparam logic [2:0] PH_DWELL  = 3'd4;
  localparam logic [2:0] PH_PLACED = 3'd5;
  localparam logic [2:0] PH_HALTED = 3'd6;

  localparam logic [2:0] CMD_MOVE   = 3'd0;
  localparam logic [2:0] CMD_PICK   = 3'd1;
  localparam logic [2:0] CMD_PLACE  = 3'd2;
  localparam logic [2:0] CMD_HOME   = 3'd3;
  localparam logic [2:0] CMD_STOP   = 3'd4;
  localparam logic [2:0] CMD_RESUME = 3'd5;

  localparam logic [3:0] POS_LAST = 4'(NUM_STATIONS + 1);

  logic               accept;
  logic [2:0]         phase_nxt;
  logic [2:0]         saved_phase;
  logic [2:0]         saved_phase_nxt;
  logic [3:0]         pos_nxt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_cnt_nxt;
  logic [DWELL_W-1:0] dwell_sel;
  logic [CNT_W-1:0]   count_nxt;
  logic               complete_nxt;
  logic               error_nxt;

  assign accept = cmd_valid && cmd_ready;

  // Dwell for the station the arm is at (pos 1 -> station 0).
  always_comb begin
    dwell_sel = '0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      if (pos == 4'(k + 1)) dwell_sel = dwell_cfg[k*DWELL_W +: DWELL_W];
    end
  end

`ifdef SCARA_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            wd_expire;

  assign wd_active = (phase == PH_WPICK) || (phase == PH_WMOVE) || (phase == PH_WPLACE);
  // Expires on the idle cycle that would bring the count to WD_LIMIT.
  assign wd_expire = wd_active && !accept && (wd_cnt == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_expire;
      if (accept || !wd_active || (phase_nxt != phase)) wd_cnt <= '0;
      else                                              wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  // Keeps the limit referenced in builds that carry no watchdog.
  logic wd_limit_unused;
  assign wd_limit_unused = (WD_LIMIT != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    phase_nxt       = phase;
    pos_nxt         = pos;
    saved_phase_nxt = saved_phase;
    dwell_cnt_nxt   = dwell_cnt;
    count_nxt       = product_count;
    complete_nxt    = 1'b0;
    error_nxt       = 1'b0;

    if (accept) begin
      // STOP is handled uniformly for every phase that can be halted.
      if ((cmd == CMD_STOP) &&
          (phase inside {PH_IDLE, PH_WPICK, PH_WMOVE, PH_WPLACE, PH_PLACED})) begin
        saved_phase_nxt = phase;
        phase_nxt       = PH_HALTED;
      end else begin
        case (phase)
          PH_IDLE: begin
            if (cmd == CMD_MOVE) begin
              pos_nxt   = '0;
              phase_nxt = PH_WPICK;
            end else error_nxt = 1'b1;
          end
          PH_WPICK: begin
            if (cmd == CMD_PICK) phase_nxt = PH_WMOVE;
            else                 error_nxt = 1'b1;
          end
          PH_WMOVE: begin
            if (cmd == CMD_MOVE) begin
              pos_nxt   = pos + 4'd1;
              phase_nxt = PH_WPLACE;
            end else error_nxt = 1'b1;
          end
          PH_WPLACE: begin
            if (cmd == CMD_PLACE) begin
              if (pos == POS_LAST) begin
                phase_nxt    = PH_PLACED;
                complete_nxt = 1'b1;
                count_nxt    = product_count + CNT_W'(1);
              end else begin
                // dwell_cfg is captured only here; later changes are ignored.
                dwell_cnt_nxt = dwell_sel;
                phase_nxt     = PH_DWELL;
              end
            end else error_nxt = 1'b1;
          end
          PH_PLACED: begin
            if (cmd == CMD_HOME) begin
              pos_nxt   = '0;
              phase_nxt = PH_IDLE;
            end else if (cmd == CMD_MOVE) begin
              pos_nxt   = '0;
              phase_nxt = PH_WPICK;
            end else error_nxt = 1'b1;
          end
          PH_HALTED: begin
            if (cmd == CMD_RESUME) phase_nxt = saved_phase;
            else if (cmd == CMD_HOME) begin
              pos_nxt   = '0;
              phase_nxt = PH_IDLE;
            end else if (cmd != CMD_STOP) error_nxt = 1'b1;
          end
          default: error_nxt = 1'b1;
        endcase
      end
    end else if (phase == PH_DWELL) begin
      // Counter reading 0 is the last dwell cycle, so value D gives D+1 cycles.
      if (dwell_cnt == '0) phase_nxt = PH_WPICK;
      else                 dwell_cnt_nxt = dwell_cnt - DWELL_W'(1);
    end else if (phase > PH_HALTED) begin
      phase_nxt = PH_IDLE;
`ifdef SCARA_SEQ_WATCHDOG_EN
    end else if (wd_expire) begin
      saved_phase_nxt = phase;
      phase_nxt       = PH_HALTED;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase            <= PH_IDLE;
      pos              <= '0;
      saved_phase      <= PH_IDLE;
      dwell_cnt        <= '0;
      product_count    <= '0;
      product_complete <= 1'b0;
      error            <= 1'b0;
      cmd_ready        <= 1'b1;
    end else begin
      phase            <= phase_nxt;
      pos              <= pos_nxt;
      saved_phase      <= saved_phase_nxt;
      dwell_cnt        <= dwell_cnt_nxt;
      product_count    <= count_nxt;
      product_complete <= complete_nxt;
      error            <= error_nxt;
      cmd_ready        <= (phase_nxt != PH_DWELL);
    end
  end

endmodule

// File: tb/tb_scara_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scara_seq_ctrl
//
// Self-checking bench for scara_seq_ctrl. Each command pushes its expected
// phase/pos/pulse/count result to a queue when driven; the entry is popped
// and compared one cycle after the DUT accepts the command. A narrow product
// counter keeps the wrap-around reachable in a short run.
// -----------------------------------------------------------------------------
module tb_scara_seq_ctrl;

  localparam int NS  = 3;
  localparam int DW  = 8;
  localparam int CW  = 3;
  localparam int WDL = 10;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_WPICK  = 3'd1;
  localparam logic [2:0] PH_WMOVE  = 3'd2;
  localparam logic [2:0] PH_WPLACE = 3'd3;
  localparam logic [2:0] PH_DWELL  = 3'd4;
  localparam logic [2:0] PH_PLACED = 3'd5;
  localparam logic [2:0] PH_HALTED = 3'd6;

  localparam logic [2:0] CMD_MOVE   = 3'd0;
  localparam logic [2:0] CMD_PICK   = 3'd1;
  localparam logic [2:0] CMD_PLACE  = 3'd2;
  localparam logic [2:0] CMD_HOME   = 3'd3;
  localparam logic [2:0] CMD_STOP   = 3'd4;
  localparam logic [2:0] CMD_RESUME = 3'd5;
  localparam logic [2:0] CMD_BAD    = 3'd7;

  localparam logic [NS*DW-1:0] CFG_BASE = {8'd5, 8'd0, 8'd2};

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd = 3'd0;
  logic            cmd_ready;
  logic [NS*DW-1:0] dwell_cfg = CFG_BASE;
  logic [2:0]      phase;
  logic [3:0]      pos;
  logic            product_complete;
  logic            error;
  logic            timeout;
  logic [CW-1:0]   product_count;

  typedef struct {
    logic [2:0]    ph;
    logic [3:0]    pos;
    logic          pc;
    logic          er;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [CW-1:0] exp_count = '0;
  int            dwell_len[NS] = '{3, 1, 6};

  scara_seq_ctrl #(
    .NUM_STATIONS(NS),
    .DWELL_W     (DW),
    .CNT_W       (CW),
    .WD_LIMIT    (WDL)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd             (cmd),
    .cmd_ready       (cmd_ready),
    .dwell_cfg       (dwell_cfg),
    .phase           (phase),
    .pos             (pos),
    .product_complete(product_complete),
    .error           (error),
    .timeout         (timeout),
    .product_count   (product_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // Offer one command, wait (bounded) for acceptance, then compare the
  // popped expectation against the outputs one cycle after acceptance.
  task automatic do_cmd(input string tag, input logic [2:0] c, input logic [2:0] ph,
                        input logic [3:0] p, input logic pc, input logic er,
                        output int stalls);
    exp_t e;
    e.ph = ph; e.pos = p; e.pc = pc; e.er = er; e.cnt = exp_count;
    sb.push_back(e);
    stalls = 0;
    @(negedge clock);
    cmd = c;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && stalls < 300) begin
      @(negedge clock);
      stalls++;
    end
    if (cmd_ready !== 1'b1) begin
      check_val({tag, "_ready_wait"}, 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
      e = sb.pop_front();
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    e = sb.pop_front();
    check_val({tag, "_phase"}, 32'(phase), 32'(e.ph));
    check_val({tag, "_pos"}, 32'(pos), 32'(e.pos));
    check_val({tag, "_complete"}, 32'(product_complete), 32'(e.pc));
    check_val({tag, "_error"}, 32'(error), 32'(e.er));
    check_val({tag, "_count"}, 32'(product_count), 32'(e.cnt));
  endtask

  // Called one cycle into DWELL; scrambles dwell_cfg to show it is not re-read.
  task automatic wait_dwell(input string tag, input int want);
    int n = 1;
    dwell_cfg = '1;
    while (n < 300) begin
      @(posedge clock);
      #1;
      if (phase !== PH_DWELL) break;
      n++;
    end
    dwell_cfg = CFG_BASE;
    check_val({tag, "_len"}, 32'(n), 32'(want));
    check_val({tag, "_exit_phase"}, 32'(phase), 32'(PH_WPICK));
    check_val({tag, "_exit_ready"}, 32'(cmd_ready), 1);
  endtask

  task automatic full_product();
    int st;
    do_cmd("fp_move0", CMD_MOVE, PH_WPICK, 4'd0, 1'b0, 1'b0, st);
    for (int s = 1; s <= NS; s++) begin
      do_cmd("fp_pick", CMD_PICK, PH_WMOVE, 4'(s - 1), 1'b0, 1'b0, st);
      do_cmd("fp_move", CMD_MOVE, PH_WPLACE, 4'(s), 1'b0, 1'b0, st);
      do_cmd("fp_place", CMD_PLACE, PH_DWELL, 4'(s), 1'b0, 1'b0, st);
      wait_dwell("fp_dwell", dwell_len[s-1]);
    end
    do_cmd("fp_pick_last", CMD_PICK, PH_WMOVE, 4'(NS), 1'b0, 1'b0, st);
    do_cmd("fp_move_out", CMD_MOVE, PH_WPLACE, 4'(NS + 1), 1'b0, 1'b0, st);
    exp_count = exp_count + 1'b1;
    do_cmd("fp_deliver", CMD_PLACE, PH_PLACED, 4'(NS + 1), 1'b1, 1'b0, st);
    @(posedge clock);
    #1;
    check_val("fp_pulse_end", 32'(product_complete), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    int  st;
    int  n;
    logic saw_to;

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_phase", 32'(phase), 32'(PH_IDLE));
    check_val("rst_pos", 32'(pos), 0);
    check_val("rst_count", 32'(product_count), 0);
    check_val("rst_complete", 32'(product_complete), 0);
    check_val("rst_error", 32'(error), 0);
    check_val("rst_timeout", 32'(timeout), 0);
    check_val("rst_ready", 32'(cmd_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;

    // Full station walk, dwell 3/1/6 cycles, one delivery.
    full_product();

    // MOVE from PLACED, then command held through DWELL.
    do_cmd("placed_move", CMD_MOVE, PH_WPICK, 4'd0, 1'b0, 1'b0, st);
    do_cmd("h_pick", CMD_PICK, PH_WMOVE, 4'd0, 1'b0, 1'b0, st);
    do_cmd("h_move", CMD_MOVE, PH_WPLACE, 4'd1, 1'b0, 1'b0, st);
    do_cmd("h_place", CMD_PLACE, PH_DWELL, 4'd1, 1'b0, 1'b0, st);
    do_cmd("held_pick", CMD_PICK, PH_WMOVE, 4'd1, 1'b0, 1'b0, st);
    check_val("held_stalls", 32'(st), 3);

    // Illegal commands in WAIT_PICK at pos 2.
    do_cmd("e_move", CMD_MOVE, PH_WPLACE, 4'd2, 1'b0, 1'b0, st);
    do_cmd("e_place", CMD_PLACE, PH_DWELL, 4'd2, 1'b0, 1'b0, st);
    wait_dwell("e_dwell", 1);
    do_cmd("bad_place", CMD_PLACE, PH_WPICK, 4'd2, 1'b0, 1'b1, st);
    do_cmd("bad_code", CMD_BAD, PH_WPICK, 4'd2, 1'b0, 1'b1, st);
    do_cmd("bad_resume", CMD_RESUME, PH_WPICK, 4'd2, 1'b0, 1'b1, st);
    do_cmd("bad_home", CMD_HOME, PH_WPICK, 4'd2, 1'b0, 1'b1, st);

    // STOP/RESUME in WAIT_MOVE at pos 2, then STOP/STOP/HOME.
    do_cmd("s_pick", CMD_PICK, PH_WMOVE, 4'd2, 1'b0, 1'b0, st);
    do_cmd("stop1", CMD_STOP, PH_HALTED, 4'd2, 1'b0, 1'b0, st);
    do_cmd("resume", CMD_RESUME, PH_WMOVE, 4'd2, 1'b0, 1'b0, st);
    do_cmd("stop2", CMD_STOP, PH_HALTED, 4'd2, 1'b0, 1'b0, st);
    do_cmd("stop_halted", CMD_STOP, PH_HALTED, 4'd2, 1'b0, 1'b0, st);
    do_cmd("halt_home", CMD_HOME, PH_IDLE, 4'd0, 1'b0, 1'b0, st);
    do_cmd("idle_home", CMD_HOME, PH_IDLE, 4'd0, 1'b0, 1'b1, st);

    // Bring the count to 5, then reset in the middle of a dwell.
    repeat (4) full_product();
    check_val("count_five", 32'(product_count), 5);
    do_cmd("r_move0", CMD_MOVE, PH_WPICK, 4'd0, 1'b0, 1'b0, st);
    do_cmd("r_pick", CMD_PICK, PH_WMOVE, 4'd0, 1'b0, 1'b0, st);
    do_cmd("r_move", CMD_MOVE, PH_WPLACE, 4'd1, 1'b0, 1'b0, st);
    do_cmd("r_place", CMD_PLACE, PH_DWELL, 4'd1, 1'b0, 1'b0, st);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    exp_count = '0;
    check_val("arst_phase", 32'(phase), 32'(PH_IDLE));
    check_val("arst_pos", 32'(pos), 0);
    check_val("arst_count", 32'(product_count), 0);
    check_val("arst_complete", 32'(product_complete), 0);
    check_val("arst_ready", 32'(cmd_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_val("post_rst_phase", 32'(phase), 32'(PH_IDLE));
    check_val("post_rst_error", 32'(error), 0);

    // Eight deliveries on a 3-bit counter wrap it back to 0.
    repeat (8) full_product();
    check_val("count_wrap", 32'(product_count), 0);

    // Idle in WAIT_PLACE.
    do_cmd("w_move0", CMD_MOVE, PH_WPICK, 4'd0, 1'b0, 1'b0, st);
    do_cmd("w_pick", CMD_PICK, PH_WMOVE, 4'd0, 1'b0, 1'b0, st);
    do_cmd("w_move", CMD_MOVE, PH_WPLACE, 4'd1, 1'b0, 1'b0, st);
`ifdef SCARA_SEQ_WATCHDOG_EN
    n = 1;
    while (n < 40) begin
      @(posedge clock);
      #1;
      if (phase !== PH_WPLACE) break;
      n++;
    end
    check_val("wd_cycles", 32'(n), WDL);
    check_val("wd_phase", 32'(phase), 32'(PH_HALTED));
    check_val("wd_timeout", 32'(timeout), 1);
    @(posedge clock);
    #1;
    check_val("wd_timeout_end", 32'(timeout), 0);
    do_cmd("wd_resume", CMD_RESUME, PH_WPLACE, 4'd1, 1'b0, 1'b0, st);
`else
    n = 0;
    saw_to = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (timeout !== 1'b0) saw_to = 1'b1;
      if (phase === PH_WPLACE) n++;
    end
    check_val("nowd_phase_cycles", 32'(n), 20);
    check_val("nowd_timeout", 32'(saw_to), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scara_seq_ctrl.md
SCARA_SEQ_CTRL -- requirements
Module: scara_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
  NUM_STATIONS  3   process stations between conveyor 1 and conveyor 2, range 1..14
  DWELL_W       8   width of each station dwell value
  CNT_W         16  width of the product counter
  WD_LIMIT      255 watchdog idle-cycle limit, used only with SCARA_SEQ_WATCHDOG_EN
REQ-002 Ports SHALL be:
  clock  in  1  single clock; all state changes on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  cmd_valid  in  1  command offered
  cmd  in  3  000 MOVE, 001 PICK, 010 PLACE, 011 HOME, 100 STOP, 101 RESUME, 110/111 invalid
  cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
  dwell_cfg  in  NUM_STATIONS*DWELL_W  station k dwell in bits [k*DWELL_W +: DWELL_W], k=0..NUM_STATIONS-1
  phase  out  3  0 IDLE, 1 WAIT_PICK, 2 WAIT_MOVE, 3 WAIT_PLACE, 4 DWELL, 5 PLACED, 6 HALTED
  pos  out  4  arm position: 0 conveyor 1, 1..NUM_STATIONS stations, NUM_STATIONS+1 conveyor 2
  product_complete  out  1  one-cycle pulse on each product delivered to conveyor 2
  error  out  1  one-cycle pulse on each accepted illegal or invalid command
  timeout  out  1  one-cycle pulse on watchdog expiry
  product_count  out  CNT_W  number of products delivered

Function
REQ-003 cmd_ready SHALL be 1 in every phase except DWELL, and 0 in DWELL.
REQ-004 All outputs SHALL be registered; an accepted command is reflected in phase, pos and the pulse outputs in the cycle after the accepting edge.
REQ-005 In IDLE, MOVE SHALL set pos=0 and go to WAIT_PICK.
REQ-006 In WAIT_PICK, PICK SHALL go to WAIT_MOVE.
REQ-007 In WAIT_MOVE, MOVE SHALL increment pos and go to WAIT_PLACE.
REQ-008 In WAIT_PLACE with pos=NUM_STATIONS+1, PLACE SHALL go to PLACED, pulse product_complete and increment product_count.
REQ-009 product_count SHALL wrap from all-ones to 0.
REQ-010 In WAIT_PLACE with pos<=NUM_STATIONS, PLACE SHALL load the dwell counter from station pos-1 of dwell_cfg and go to DWELL.
REQ-011 dwell_cfg SHALL be sampled only on that PLACE acceptance; changes during DWELL SHALL have no effect.
REQ-012 DWELL SHALL decrement the counter once per cycle and go to WAIT_PICK in the cycle after the counter reads 0; a dwell value of 0 SHALL give exactly 1 cycle in DWELL, and a value D SHALL give D+1 cycles.
REQ-013 In PLACED, HOME SHALL set pos=0 and go to IDLE; MOVE SHALL set pos=0 and go to WAIT_PICK.
REQ-014 In IDLE, WAIT_PICK, WAIT_MOVE, WAIT_PLACE or PLACED, STOP SHALL save the current phase and go to HALTED with pos held.
REQ-015 In HALTED, RESUME SHALL restore the saved phase, and HOME SHALL set pos=0 and go to IDLE.
REQ-016 In HALTED, STOP SHALL be accepted with no effect and no error.
REQ-017 Any other accepted command SHALL pulse error and leave phase and pos unchanged; this covers codes 110/111, RESUME outside HALTED and out-of-sequence commands.
REQ-018 HOME SHALL be legal only in PLACED and HALTED; HOME in any other phase SHALL pulse error.

Reset
REQ-019 While reset_n=0, outputs SHALL be: phase=IDLE, pos=0, product_count=0, product_complete=0, error=0, timeout=0, cmd_ready=1; the dwell counter, watchdog counter and saved phase SHALL be 0.
REQ-020 Reset asserted mid-DWELL or mid-HALTED SHALL abandon the operation, with no pulse issued.
REQ-021 The first command SHALL be acceptable at the first rising edge after reset_n deasserts.

Configuration
REQ-022 With SCARA_SEQ_WATCHDOG_EN defined, a counter SHALL count consecutive cycles spent in WAIT_PICK, WAIT_MOVE or WAIT_PLACE with no accepted command.
REQ-023 On reaching WD_LIMIT, the watchdog SHALL save the phase, go to HALTED and pulse timeout; any accepted command or phase change SHALL clear the counter.
REQ-024 Without SCARA_SEQ_WATCHDOG_EN, timeout SHALL be constant 0 and no watchdog logic SHALL exist.

Verification
REQ-025 Full cycle, NUM_STATIONS=3, dwell={2,0,5}: MOVE, then (PICK, MOVE, PLACE)x4 -> DWELL lasts 3, 1 and 6 cycles; pos goes 0..4; product_complete pulses once; product_count=1.
REQ-026 cmd_valid held high during DWELL -> cmd_ready=0, the command is not consumed and is accepted on the first WAIT_PICK cycle.
REQ-027 PLACE in WAIT_PICK, then cmd=111 -> two error pulses; phase and pos unchanged.
REQ-028 STOP in WAIT_MOVE at pos=2, then RESUME -> HALTED then WAIT_MOVE at pos=2; STOP then HOME -> IDLE at pos=0.
REQ-029 reset_n pulsed low asynchronously mid-DWELL with product_count=5 -> immediately IDLE, pos=0, product_count=0.
REQ-030 With SCARA_SEQ_WATCHDOG_EN and WD_LIMIT=10, idle in WAIT_PLACE -> timeout pulse and HALTED after 10 cycles; with the macro undefined -> remains in WAIT_PLACE and timeout stays 0.
